// File: rtl/lfsr_checker_pkg.sv
// lfsr_checker_pkg: shared LFSR word width, feedback taps and checker state encoding.
// Defaults to an 8-bit word with taps 7,5,4,3 unless BITN/R_1..R_4 are predefined.
`ifndef BITN
`define BITN 8
`endif
`ifndef R_1
`define R_1 7
`endif
`ifndef R_2
`define R_2 5
`endif
`ifndef R_3
`define R_3 4
`endif
`ifndef R_4
`define R_4 3
`endif

package lfsr_checker_pkg;
    localparam int BITN = `BITN;
    localparam int R1 = `R_1;
    localparam int R2 = `R_2;
    localparam int R3 = `R_3;
    localparam int R4 = `R_4;
    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } checkerState;
endpackage

// File: rtl/lfsr_checker_if.sv
// lfsr_checker_if: observed word stream into the checker and its status outputs.
// bitErrCount exists only when LFSR_CHECKER_BITERR_EN is defined.
interface lfsr_checker_if #(
    parameter int ERR_W = 16
) ();
    import lfsr_checker_pkg::*;
    logic            validIn;
    logic [BITN-1:0] dataIn;
    logic            locked;
    logic            errPulse;
    logic [ERR_W-1:0] errCount;
    logic            lossPulse;
`ifdef LFSR_CHECKER_BITERR_EN
    logic [ERR_W-1:0] bitErrCount;
    modport master (output validIn, dataIn, input locked, errPulse, errCount, lossPulse, bitErrCount);
    modport slave (input validIn, dataIn, output locked, errPulse, errCount, lossPulse, bitErrCount);
`else
    modport master (output validIn, dataIn, input locked, errPulse, errCount, lossPulse);
    modport slave (input validIn, dataIn, output locked, errPulse, errCount, lossPulse);
`endif
endinterface

// File: rtl/lfsr_checker_lfsr_step.sv
// lfsr_step: one shift of the LFSR; the all-zero word feeds a 1 so it never sticks.
module lfsr_step
    import lfsr_checker_pkg::*;
(
    input  logic [BITN-1:0] w,
    output logic [BITN-1:0] nextW
);
    assign nextW = {w[BITN-2:0], w[R1] ^ w[R2] ^ w[R3] ^ w[R4] ^ (w == '0)};
endmodule

// File: rtl/lfsr_checker.sv
// lfsr_checker: self-synchronising LFSR stream monitor with lock/loss tracking and error counting.
// Define LFSR_CHECKER_BITERR_EN to add a saturating count of flipped bits while locked.
module lfsr_checker
    import lfsr_checker_pkg::*;
#(
    parameter int LOCK_CNT = 4,
    parameter int LOSS_CNT = 3,
    parameter int ERR_W    = 16
) (
    input logic clk,
    input logic reset,
    lfsr_checker_if.slave bus
);
    localparam int OKW  = $clog2(LOCK_CNT + 1);
    localparam int BADW = $clog2(LOSS_CNT + 1);
    checkerState     state;
    logic [BITN-1:0] expW;
    logic [BITN-1:0] nextIn;
    logic [BITN-1:0] nextExp;
    logic [OKW-1:0]  okCnt;
    logic [BADW-1:0] badCnt;
    logic            match;
    lfsr_step stepIn (.w(bus.dataIn), .nextW(nextIn));
    lfsr_step stepExp (.w(expW), .nextW(nextExp));
    assign match = bus.dataIn == expW;
`ifdef LFSR_CHECKER_BITERR_EN
    logic [ERR_W:0] bitSum;
    assign bitSum = {1'b0, bus.bitErrCount} + (ERR_W + 1)'($countones(bus.dataIn ^ expW));
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= HUNT;
            expW          <= '0;
            okCnt         <= '0;
            badCnt        <= '0;
            bus.locked    <= 1'b0;
            bus.errPulse  <= 1'b0;
            bus.lossPulse <= 1'b0;
            bus.errCount  <= '0;
`ifdef LFSR_CHECKER_BITERR_EN
            bus.bitErrCount <= '0;
`endif
        end else begin
            bus.errPulse  <= 1'b0;
            bus.lossPulse <= 1'b0;
            if (bus.validIn) begin
                case (state)
                    HUNT: begin
                        expW  <= nextIn;
                        okCnt <= '0;
                        state <= VERIFY;
                    end
                    VERIFY: begin
                        // a mismatching word reseeds immediately instead of returning to HUNT
                        expW  <= match ? nextExp : nextIn;
                        okCnt <= match ? okCnt + 1'b1 : '0;
                        if (match && okCnt == OKW'(LOCK_CNT - 1)) begin
                            state      <= LOCKED;
                            bus.locked <= 1'b1;
                            badCnt     <= '0;
                            okCnt      <= '0;
                        end
                    end
                    LOCKED: begin
                        expW <= nextExp;
                        if (match) begin
                            badCnt <= '0;
                        end else begin
                            bus.errPulse <= 1'b1;
                            bus.errCount <= &bus.errCount ? bus.errCount : bus.errCount + 1'b1;
`ifdef LFSR_CHECKER_BITERR_EN
                            bus.bitErrCount <= bitSum[ERR_W] ? '1 : bitSum[ERR_W-1:0];
`endif
                            badCnt <= badCnt + 1'b1;
                            if (badCnt == BADW'(LOSS_CNT - 1)) begin
                                bus.lossPulse <= 1'b1;
                                bus.locked    <= 1'b0;
                                badCnt        <= '0;
                                state         <= HUNT;
                            end
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end
endmodule
